// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
//   Shared definitions for the ADC scan path and the voltage display path:
//   default channel count and sample width, the one-hot sequencer state
//   encoding, and a constant-width helper.
// ---------------------------------------------------------------------------
package adc_pkg;

    localparam int N_CH_DEF   = 4;
    localparam int DATA_W_DEF = 12;

    // One-hot state encoding for the scan sequencer.
    typedef enum logic [5:0] {
        IDLE      = 6'b000001,
        SELECT    = 6'b000010,
        CONVERT   = 6'b000100,
        WAIT_DONE = 6'b001000,
        NEXT_CH   = 6'b010000,
        PUBLISH   = 6'b100000
    } state_e;

    // Ceiling log2; clog2(1) = 0. Callers needing at least one bit clamp it.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/adc_period_timer.sv
// ---------------------------------------------------------------------------
// adc_period_timer
//   Free-running counter 0..PERIOD-1 that wraps, with a one-cycle wrap pulse
//   in the cycle the counter holds PERIOD-1.
// Ports
//   clk     in   clock
//   rst     in   synchronous, active-high reset (counter -> 0)
//   wrap_o  out  high while the counter is at its last value
// ---------------------------------------------------------------------------
module adc_period_timer
    import adc_pkg::*;
#(
    parameter int PERIOD = 650_000
) (
    input  logic clk,
    input  logic rst,
    output logic wrap_o
);

    localparam int CNT_W = (PERIOD > 1) ? clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign wrap_o = (count_q == LAST);

    always_comb begin
        count_d = wrap_o ? '0 : count_q + CNT_W'(1);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// ---------------------------------------------------------------------------
// adc_channel_sequencer
//   Multi-channel ADC scan sequencer. Each period it scans the enabled
//   channels in ascending order, averages 2^AVG_LOG2 conversions per channel,
//   flags channels whose converter never answers, and publishes the whole
//   frame at once with a one-cycle frame_tick_o.
// Ports
//   clk           in   clock
//   rst           in   synchronous, active-high reset
//   en_mask_i     in   channel enables, captured at frame start
//   adc_sel_o     out  one-hot channel select to the ADC mux (0 when idle)
//   adc_start_o   out  one-cycle conversion request
//   adc_done_i    in   one-cycle conversion complete, adc_data_i valid with it
//   adc_data_i    in   conversion result
//   ch_data_o     out  published results, channel k at [k*DATA_W +: DATA_W]
//   ch_err_o      out  per-channel timeout flags of the last published frame
//   frame_tick_o  out  one-cycle pulse in the cycle ch_data_o/ch_err_o change
//   busy_o        out  high from frame start through the frame_tick_o cycle
//   overrun_o     out  sticky: a period elapsed while a frame was running
// ---------------------------------------------------------------------------
module adc_channel_sequencer
    import adc_pkg::*;
#(
    parameter int N_CH     = N_CH_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int PERIOD   = 650_000,
    parameter int SETTLE   = 16,
    parameter int AVG_LOG2 = 0,
    parameter int TIMEOUT  = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          en_mask_i,
    output logic [N_CH-1:0]          adc_sel_o,
    output logic                     adc_start_o,
    input  logic                     adc_done_i,
    input  logic [DATA_W-1:0]        adc_data_i,
    output logic [N_CH*DATA_W-1:0]   ch_data_o,
    output logic [N_CH-1:0]          ch_err_o,
    output logic                     frame_tick_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam int CH_W    = (N_CH > 1) ? clog2(N_CH) : 1;
    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int CNV_W   = AVG_LOG2 + 1;
    localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W   = clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNV_W-1:0] CNV_LAST     = CNV_W'((1 << AVG_LOG2) - 1);

    state_e              state_q,      state_d;
    logic [CH_W-1:0]     ch_idx_q,     ch_idx_d;
    logic [N_CH-1:0]     mask_q,       mask_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [CNV_W-1:0]    cnv_q,        cnv_d;
    logic [ACC_W-1:0]    acc_q,        acc_d;
    logic [DATA_W-1:0]   shadow_q [N_CH];
    logic [DATA_W-1:0]   shadow_d [N_CH];
    logic [N_CH-1:0]     err_shadow_q, err_shadow_d;
    logic [N_CH*DATA_W-1:0] ch_data_q, ch_data_d;
    logic [N_CH-1:0]     ch_err_q,     ch_err_d;
    logic                tick_q,       tick_d;
    logic                overrun_q,    overrun_d;

    logic                wrap;
    logic [N_CH-1:0]     above_mask;
    logic [CH_W:0]       first_hit;
    logic [CH_W:0]       next_hit;
    logic [ACC_W-1:0]    sum;
    logic [DATA_W-1:0]   avg;

    adc_period_timer #(
        .PERIOD (PERIOD)
    ) u_period_timer (
        .clk    (clk),
        .rst    (rst),
        .wrap_o (wrap)
    );

    // Lowest set bit of a channel mask as {found, index}.
    function automatic logic [CH_W:0] lowest_set(input logic [N_CH-1:0] bits);
        logic [CH_W:0] result;
        result = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bits[k]) begin
                result = {1'b1, CH_W'(k)};
            end
        end
        return result;
    endfunction

    // Enabled channels strictly above the current one. For the top channel
    // the shifted constant overflows to 0, leaving an all-zero mask.
    assign above_mask = mask_q & ~((N_CH'(2) << ch_idx_q) - N_CH'(1));
    assign first_hit  = lowest_set(en_mask_i);
    assign next_hit   = lowest_set(above_mask);

    // The accumulator is wide enough for 2^AVG_LOG2 full-scale samples, so
    // the sum never wraps; the top DATA_W bits are the truncated mean.
    assign sum = acc_q + ACC_W'(adc_data_i);
    assign avg = sum[ACC_W-1 -: DATA_W];

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ch_idx_d     = ch_idx_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        cnv_d        = cnv_q;
        acc_d        = acc_q;
        shadow_d     = shadow_q;
        err_shadow_d = err_shadow_q;
        ch_data_d    = ch_data_q;
        ch_err_d     = ch_err_q;
        tick_d       = 1'b0;
        // A frame request that finds the sequencer busy is dropped, not queued.
        overrun_d    = overrun_q | (wrap && (state_q != IDLE));

        unique case (state_q)
            IDLE: begin
                if (wrap) begin
                    mask_d = en_mask_i;
                    if (first_hit[CH_W]) begin
                        ch_idx_d = first_hit[CH_W-1:0];
                        cnt_d    = '0;
                        state_d  = SELECT;
                    end else begin
                        state_d  = PUBLISH;
                    end
                end
            end

            SELECT: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = CONVERT;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            CONVERT: begin
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (adc_done_i) begin
                    cnt_d = '0;
                    if (cnv_q == CNV_LAST) begin
                        shadow_d[ch_idx_q] = avg;
                        acc_d   = '0;
                        cnv_d   = '0;
                        state_d = NEXT_CH;
                    end else begin
                        acc_d   = sum;
                        cnv_d   = cnv_q + CNV_W'(1);
                        state_d = CONVERT;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Silent converter: flag it, drop the partial sum and keep
                    // the channel's previous result.
                    err_shadow_d[ch_idx_q] = 1'b1;
                    acc_d   = '0;
                    cnv_d   = '0;
                    state_d = NEXT_CH;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end

            NEXT_CH: begin
                if (next_hit[CH_W]) begin
                    ch_idx_d = next_hit[CH_W-1:0];
                    cnt_d    = '0;
                    state_d  = SELECT;
                end else begin
                    state_d  = PUBLISH;
                end
            end

            PUBLISH: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (mask_q[k]) begin
                        ch_data_d[k*DATA_W +: DATA_W] = shadow_q[k];
                    end
                end
                ch_err_d     = err_shadow_q & mask_q;
                err_shadow_d = '0;
                tick_d       = 1'b1;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_idx_q     <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            cnv_q        <= '0;
            acc_q        <= '0;
            // NOTE: the shadow array is small register storage that must read
            // as zero after reset, so it is cleared here rather than left to
            // power-up contents like a RAM would be.
            shadow_q     <= '{default: '0};
            err_shadow_q <= '0;
            ch_data_q    <= '0;
            ch_err_q     <= '0;
            tick_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_idx_q     <= ch_idx_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            cnv_q        <= cnv_d;
            acc_q        <= acc_d;
            shadow_q     <= shadow_d;
            err_shadow_q <= err_shadow_d;
            ch_data_q    <= ch_data_d;
            ch_err_q     <= ch_err_d;
            tick_q       <= tick_d;
            overrun_q    <= overrun_d;
        end
    end

    // Results and the tick are registered together, so frame_tick_o marks the
    // first cycle the new frame is visible; busy_o covers that cycle too.
    assign adc_start_o  = (state_q == CONVERT);
    assign adc_sel_o    = (state_q inside {SELECT, CONVERT, WAIT_DONE, NEXT_CH})
                          ? (N_CH'(1) << ch_idx_q) : '0;
    assign ch_data_o    = ch_data_q;
    assign ch_err_o     = ch_err_q;
    assign frame_tick_o = tick_q;
    assign busy_o       = (state_q != IDLE) || tick_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_channel_sequencer
//   Randomised frame-level bench. A behavioural ADC answers conversion
//   requests (or stays silent on chosen channels); the expected frame is
//   computed from the samples actually returned, using the averaging,
//   timeout and keep-old-value rules directly.
// ---------------------------------------------------------------------------
module tb_adc_channel_sequencer;

    localparam int N_CH     = 4;
    localparam int DATA_W   = 12;
    localparam int PERIOD   = 600;
    localparam int SETTLE   = 4;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 80;
    localparam int N_AVG    = 1 << AVG_LOG2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_CH-1:0]        en_mask;
    logic [N_CH-1:0]        adc_sel_o;
    logic                   adc_start_o;
    logic                   adc_done;
    logic [DATA_W-1:0]      adc_data;
    logic [N_CH*DATA_W-1:0] ch_data_o;
    logic [N_CH-1:0]        ch_err_o;
    logic                   frame_tick_o;
    logic                   busy_o;
    logic                   overrun_o;

    adc_channel_sequencer #(
        .N_CH     (N_CH),
        .DATA_W   (DATA_W),
        .PERIOD   (PERIOD),
        .SETTLE   (SETTLE),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_mask_i    (en_mask),
        .adc_sel_o    (adc_sel_o),
        .adc_start_o  (adc_start_o),
        .adc_done_i   (adc_done),
        .adc_data_i   (adc_data),
        .ch_data_o    (ch_data_o),
        .ch_err_o     (ch_err_o),
        .frame_tick_o (frame_tick_o),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario controls (written by the main sequence).
    int  dead_ans [N_CH];   // -1: always answers; k: answers k requests then goes silent
    int  data_mode;         // 0 random, 1 full scale, 2 ramp 10.., 3 100*(ch+1)
    bit  slow;
    int  gen;               // bumped on reset to void in-flight conversions
    int  stray_cnt;

    // Observations made by the ADC model during the current frame.
    int  samples  [N_CH][$];
    int  answered [N_CH];
    int  seq [$];

    // Reference results.
    int  exp_data [N_CH];
    bit  exp_err  [N_CH];
    bit  exp_overrun;
    int  prev_start;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural ADC: answers each request after a delay with a sample.
    initial begin : adc_model
        int pend_cnt;
        int pend_gen;
        int pend_ch;
        int pend_data;
        int stray_seen;
        pend_cnt   = 0;
        pend_gen   = 0;
        pend_ch    = 0;
        pend_data  = 0;
        stray_seen = 0;
        adc_done   = 1'b0;
        adc_data   = '0;
        forever begin
            @(negedge clk);
            adc_done = 1'b0;
            if (stray_cnt != stray_seen) begin
                stray_seen = stray_cnt;
                adc_done   = 1'b1;
                adc_data   = 12'hABC;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0 && pend_gen == gen) begin
                    adc_done = 1'b1;
                    adc_data = DATA_W'(pend_data);
                    samples[pend_ch].push_back(pend_data);
                end
            end
            if (!rst && adc_start_o) begin
                int ch;
                ch = 0;
                for (int k = 0; k < N_CH; k++) if (adc_sel_o[k]) ch = k;
                check("start_sel_onehot", $onehot(adc_sel_o), 1);
                seq.push_back(ch);
                if (dead_ans[ch] < 0 || answered[ch] < dead_ans[ch]) begin
                    case (data_mode)
                        1:       pend_data = 4095;
                        2:       pend_data = 10 + answered[ch];
                        3:       pend_data = 100 * (ch + 1);
                        default: pend_data = int'($urandom_range(0, 4095));
                    endcase
                    answered[ch]++;
                    pend_ch  = ch;
                    pend_gen = gen;
                    pend_cnt = slow ? 70 : int'($urandom_range(1, 12));
                end
            end
        end
    end

    task automatic check_all_zero();
        check("rst_adc_sel",    adc_sel_o,    0);
        check("rst_adc_start",  adc_start_o,  0);
        check("rst_ch_data",    ch_data_o,    0);
        check("rst_ch_err",     ch_err_o,     0);
        check("rst_frame_tick", frame_tick_o, 0);
        check("rst_busy",       busy_o,       0);
        check("rst_overrun",    overrun_o,    0);
    endtask

    // Runs one frame: configure, optionally check the start time, wait for
    // the tick, then compare against the reference.
    task automatic do_frame(input logic [N_CH-1:0] mask, input int mode, input bit spacing);
        bit ok;
        int exp_seq [$];
        en_mask   = mask;
        data_mode = mode;
        for (int ch = 0; ch < N_CH; ch++) begin
            samples[ch].delete();
            answered[ch] = 0;
        end
        seq.delete();

        if (spacing) begin
            ok = 1'b0;
            for (int i = 0; i < 2 * PERIOD; i++) begin
                @(negedge clk);
                if (busy_o) begin
                    ok = 1'b1;
                    break;
                end
            end
            check("frame_start_gap", ok ? cyc - prev_start : -1, PERIOD);
            prev_start = cyc;
        end

        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (frame_tick_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("frame_tick_timeout", 0, 1);
            return;
        end

        for (int ch = 0; ch < N_CH; ch++) begin
            exp_err[ch] = 1'b0;
            if (mask[ch]) begin
                int n_start;
                n_start = (dead_ans[ch] < 0) ? N_AVG : dead_ans[ch] + 1;
                repeat (n_start) exp_seq.push_back(ch);
                if (dead_ans[ch] < 0) begin
                    int total;
                    total = 0;
                    foreach (samples[ch][i]) total += samples[ch][i];
                    exp_data[ch] = total / N_AVG;
                end else begin
                    exp_err[ch] = 1'b1;
                end
            end
        end

        for (int ch = 0; ch < N_CH; ch++) begin
            check($sformatf("ch_data[%0d]", ch), ch_data_o[ch*DATA_W +: DATA_W], exp_data[ch]);
            check($sformatf("ch_err[%0d]", ch), ch_err_o[ch], exp_err[ch]);
        end
        check("tick_sel_idle", adc_sel_o, 0);
        check("tick_busy", busy_o, 1);
        check("overrun", overrun_o, exp_overrun);
        check("start_count", seq.size(), exp_seq.size());
        for (int i = 0; i < seq.size() && i < exp_seq.size(); i++) begin
            check($sformatf("start_ch[%0d]", i), seq[i], exp_seq[i]);
        end
    endtask

    initial begin : watchdog
        #800_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst         = 1'b1;
        en_mask     = '0;
        data_mode   = 0;
        slow        = 1'b0;
        gen         = 0;
        stray_cnt   = 0;
        exp_overrun = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) begin
            dead_ans[ch] = -1;
            exp_data[ch] = 0;
            exp_err[ch]  = 1'b0;
        end

        repeat (3) @(negedge clk);
        check_all_zero();
        rst        = 1'b0;
        prev_start = cyc;

        // Directed frames.
        do_frame(4'hF, 3, 1);                 // 100,200,300,400
        do_frame(4'hF, 1, 1);                 // full-scale averaging
        do_frame(4'b0101, 0, 1);              // ch1/ch3 keep full scale
        dead_ans[2] = 0;
        do_frame(4'hF, 2, 1);                 // ch2 silent, others ramp -> 11
        dead_ans[2] = -1;
        do_frame(4'hF, 0, 1);                 // ch2 recovers, error clears
        do_frame(4'h0, 0, 1);                 // empty frame
        dead_ans[1] = 2;
        do_frame(4'hF, 1, 1);                 // ch1 dies mid-average, partial dropped
        dead_ans[1] = -1;

        // Random frames.
        for (int f = 0; f < 12; f++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                dead_ans[ch] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            end
            do_frame(N_CH'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 1);
        end
        for (int ch = 0; ch < N_CH; ch++) dead_ans[ch] = -1;

        // Slow converter: frames longer than the period.
        slow        = 1'b1;
        exp_overrun = 1'b1;
        do_frame(4'hF, 0, 0);
        do_frame(4'hF, 3, 0);

        // Reset while waiting on channel 1.
        begin
            bit found;
            found = 1'b0;
            en_mask = 4'hF;
            for (int i = 0; i < 4000; i++) begin
                @(negedge clk);
                if (adc_start_o && adc_sel_o == 4'b0010) begin
                    found = 1'b1;
                    break;
                end
            end
            check("reach_ch1_wait", found, 1);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_all_zero();
            gen++;
            for (int ch = 0; ch < N_CH; ch++) begin
                exp_data[ch] = 0;
                exp_err[ch]  = 1'b0;
            end
            exp_overrun = 1'b0;
            slow        = 1'b0;
            @(negedge clk);
            rst        = 1'b0;
            prev_start = cyc;
            stray_cnt++;
        end
        do_frame(4'hF, 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
